// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types for the latency RAM model.
// Holds the RAM handshake state type and the counter width.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   localparam int LAT_W = 4;

endpackage

// File: rtl/latency_ram_if.sv
// Controller <-> RAM request/response bundle.
// The master holds its request steady until it sees ACCESS.
interface latency_ram_if;
   import cpu_types_pkg::*;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport master (
      output ramREN, ramWEN, ramaddr, ramstore,
      input  ramload, ramstate
   );

   modport slave (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate
   );

endinterface

// File: rtl/ram_array.sv
// DEPTH x 32 storage: one synchronous write port,
// one asynchronous read port; contents are not reset.
module ram_array
   import cpu_types_pkg::*;
#(
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  word_t         wdata,
   input  logic [AW-1:0] raddr,
   output word_t         rdata
);

   word_t mem_q [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/latency_ram.sv
// Fixed-latency RAM responder (IDLE/COUNT FSM + capture regs).
// Define RAM_ERROR_CHECK_EN to flag REN&&WEN and out-of-range words.
module latency_ram
   import cpu_types_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input logic          CLK,
   input logic          nRST,
   latency_ram_if.slave ram
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] COUNT = 1'b1;

   localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LAT - 1);

   logic [0:0]       st_q, st_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic [29:0]      idx_q, idx_d;
   word_t            store_q, store_d;

   logic        req, err, match;
   logic        access, we;
   logic [29:0] idx_in;
   logic        addr_unused;
   word_t       rdata;

   assign req         = ram.ramREN | ram.ramWEN;
   assign idx_in      = ram.ramaddr[31:2];
   assign addr_unused = ^ram.ramaddr[1:0];

`ifdef RAM_ERROR_CHECK_EN
   assign err = (ram.ramREN & ram.ramWEN)
              | ({2'b00, idx_in} >= 32'(DEPTH));
`else
   assign err = 1'b0;
`endif

   // Any change to the held request aborts the access.
   assign match = req
                & (ram.ramWEN == op_q)
                & (idx_in == idx_q)
                & (ram.ramstore == store_q);

   always_comb begin
      st_d         = st_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      idx_d        = idx_q;
      store_d      = store_q;
      access       = 1'b0;
      ram.ramstate = FREE;
      if (err) begin
         ram.ramstate = ERROR;
         st_d         = IDLE;
         cnt_d        = '0;
      end else begin
         unique case (1'b1)
            (st_q == IDLE): begin
               if (req) begin
                  ram.ramstate = BUSY;
                  op_d         = ram.ramWEN;
                  idx_d        = idx_in;
                  store_d      = ram.ramstore;
                  cnt_d        = LAT_M1;
                  st_d         = COUNT;
               end
            end
            (st_q == COUNT): begin
               if (!match) begin
                  ram.ramstate = req ? BUSY : FREE;
                  cnt_d        = '0;
                  st_d         = IDLE;
               end else if (cnt_q != '0) begin
                  ram.ramstate = BUSY;
                  cnt_d        = cnt_q - 1'b1;
               end else begin
                  ram.ramstate = ACCESS;
                  access       = 1'b1;
                  st_d         = IDLE;
               end
            end
            default: st_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         st_q    <= IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         idx_q   <= '0;
         store_q <= '0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         store_q <= store_d;
      end
   end

   assign we          = access & op_q;
   assign ram.ramload = (access & ~op_q) ? rdata : '0;

   ram_array #(.DEPTH(DEPTH)) u_array (
      .CLK   (CLK),
      .we    (we),
      .waddr (idx_q[AW-1:0]),
      .wdata (store_q),
      .raddr (idx_q[AW-1:0]),
      .rdata (rdata)
   );

endmodule
